// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - walks instruction RAM from START_ADDR and issues words over valid/ready
module instr_fetch_sequencer #(
  parameter logic [7:0] END_OF_PROGRAM = 8'hFF,
  parameter int         MEM_DEPTH      = 128,
  parameter logic [7:0] START_ADDR     = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] ram_address,
  output logic       ram_enable,
  input  logic [7:0] ram_data,
  output logic [7:0] instr_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_count,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

  state_t     state;
  logic [8:0] next_addr;

  assign next_addr = {1'b0, ram_address} + 9'd1;

  // ram_enable is registered on entry to FETCH and already qualified by the
  // address range, so an out-of-range FETCH never strobes the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_address <= 8'd0;
      ram_enable  <= 1'b0;
      instr_data  <= 8'd0;
      instr_valid <= 1'b0;
      instr_count <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            instr_count <= 8'd0;
            error       <= 1'b0;
            ram_address <= START_ADDR;
            ram_enable  <= ({1'b0, START_ADDR} < DEPTH9);
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          ram_enable <= 1'b0;
          if ({1'b0, ram_address} >= DEPTH9) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (ram_data == END_OF_PROGRAM) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            instr_data  <= ram_data;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
            ram_address <= next_addr[7:0];
            ram_enable  <= (next_addr < DEPTH9);
            state       <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - directed vector bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] ram_address;
  logic       ram_enable;
  logic [7:0] ram_data;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_count;
  logic       busy;
  logic       done;
  logic       error;

  logic [7:0] mem [256];
  logic [7:0] acc [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ram_data = ram_enable ? mem[ram_address] : 8'h00;

  instr_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_address(ram_address), .ram_enable(ram_enable), .ram_data(ram_data),
    .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_count(instr_count), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic       start;
    logic       ready;
    logic [7:0] addr;
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vt [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  ram_address, 0);
    chk({tag, "_en"},    ram_enable, 0);
    chk({tag, "_data"},  instr_data, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_cnt"},   instr_count, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   error, 0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    mem[0] = 8'd4; mem[1] = 8'd3; mem[2] = 8'd8; mem[3] = 8'd5;
  endtask

  // Pulses start, then serves the handshake, stalling each instruction for
  // 'stall' cycles; accepted words are collected in acc.
  task automatic run_prog(input int stall, input int budget, output bit finished);
    int waits;
    bit holding;
    logic [7:0] held;
    acc.delete();
    waits = 0; holding = 0; held = 8'h00; finished = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (busy && !instr_valid && ram_address >= 8'd128)
        chk("en_out_of_range", ram_enable, 0);
      if (instr_valid) begin
        if (holding) chk("stall_stable", instr_data, held);
        if (waits < stall) begin
          instr_ready = 1'b0; waits++; holding = 1; held = instr_data;
        end else begin
          instr_ready = 1'b1; acc.push_back(instr_data); waits = 0; holding = 0;
        end
      end else begin
        instr_ready = 1'b1;
      end
      step();
      if (done) begin
        finished = 1;
        break;
      end
    end
    chk("run_terminated", finished, 1);
  endtask

  task automatic chk_prog_seq(input string tag);
    logic [7:0] exp [4];
    exp[0] = 8'd4; exp[1] = 8'd3; exp[2] = 8'd8; exp[3] = 8'd5;
    chk({tag, "_len"}, acc.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < acc.size()) chk({tag, "_item"}, acc[i], exp[i]);
  endtask

  initial begin
    bit fin;
    bit found;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    load_prog();
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // start pulses in cycle 2 (ISSUE) and cycle 10 (DONE) must be ignored
    //        start ready addr en valid data cnt busy done err
    vt[0]  = '{1, 1, 8'd0, 1, 0, 8'd0, 8'd0, 1, 0, 0};
    vt[1]  = '{0, 1, 8'd0, 0, 1, 8'd4, 8'd0, 1, 0, 0};
    vt[2]  = '{1, 1, 8'd1, 1, 0, 8'd4, 8'd1, 1, 0, 0};
    vt[3]  = '{0, 1, 8'd1, 0, 1, 8'd3, 8'd1, 1, 0, 0};
    vt[4]  = '{0, 1, 8'd2, 1, 0, 8'd3, 8'd2, 1, 0, 0};
    vt[5]  = '{0, 1, 8'd2, 0, 1, 8'd8, 8'd2, 1, 0, 0};
    vt[6]  = '{0, 1, 8'd3, 1, 0, 8'd8, 8'd3, 1, 0, 0};
    vt[7]  = '{0, 1, 8'd3, 0, 1, 8'd5, 8'd3, 1, 0, 0};
    vt[8]  = '{0, 1, 8'd4, 1, 0, 8'd5, 8'd4, 1, 0, 0};
    vt[9]  = '{0, 1, 8'd4, 0, 0, 8'd5, 8'd4, 0, 1, 0};
    vt[10] = '{1, 1, 8'd4, 0, 0, 8'd5, 8'd4, 0, 0, 0};
    vt[11] = '{0, 1, 8'd4, 0, 0, 8'd5, 8'd4, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      start = vt[i].start;
      instr_ready = vt[i].ready;
      step();
      chk("tbl_addr",  ram_address, vt[i].addr);
      chk("tbl_en",    ram_enable,  vt[i].en);
      chk("tbl_valid", instr_valid, vt[i].valid);
      chk("tbl_data",  instr_data,  vt[i].data);
      chk("tbl_cnt",   instr_count, vt[i].cnt);
      chk("tbl_busy",  busy,        vt[i].busy);
      chk("tbl_done",  done,        vt[i].done);
      chk("tbl_err",   error,       vt[i].err);
    end
    start = 1'b0;

    // stalled handshake
    run_prog(3, 100, fin);
    chk_prog_seq("stall_seq");
    chk("stall_cnt", instr_count, 4);
    chk("stall_err", error, 0);
    step();

    // terminator at START_ADDR
    mem[0] = 8'hFF;
    start = 1'b1; step(); start = 1'b0;
    chk("term0_c1_done", done, 0);
    chk("term0_c1_valid", instr_valid, 0);
    step();
    chk("term0_c2_done", done, 1);
    chk("term0_c2_valid", instr_valid, 0);
    chk("term0_cnt", instr_count, 0);
    step();
    chk("term0_done_pulse", done, 0);

    // no terminator: run off the end of memory
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    run_prog(0, 600, fin);
    chk("oob_issued", acc.size(), 128);
    chk("oob_err", error, 1);
    chk("oob_addr", ram_address, 128);
    chk("oob_cnt", instr_count, 128);
    step();
    chk("oob_err_sticky", error, 1);
    mem[0] = 8'hFF;
    start = 1'b1; step(); start = 1'b0;
    chk("restart_err_clear", error, 0);
    step();
    chk("restart_done", done, 1);
    chk("restart_err", error, 0);
    step();

    // reset in the middle of ISSUE for the second instruction
    load_prog();
    start = 1'b1; step(); start = 1'b0;
    instr_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid && instr_data == 8'd3) begin
        found = 1;
        break;
      end
      step();
    end
    chk("rst_mid_reached", found, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rst_mid");
    step();
    chk("rst_mid_idle_busy", busy, 0);
    run_prog(0, 100, fin);
    chk_prog_seq("after_rst_seq");
    chk("after_rst_cnt", instr_count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Downstream consumer of the instruction RAM: walks RAM addresses from a start address, reads one 8-bit instruction per step and hands it to the network controller over a valid/ready handshake.
- Stops at the END_OF_PROGRAM word (8'hFF), or at the end of the memory if no terminator is found.
- Reports busy/done/error status and a count of the instructions issued.

Parameters:
- END_OF_PROGRAM, 8'hFF, terminator value; never issued downstream.
- MEM_DEPTH, 128, number of valid RAM words; addresses at or above this are out of range.
- START_ADDR, 8'd0, first address fetched after start.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin program execution; sampled only in IDLE
- ram_address  output  8  address driven to the instruction RAM
- ram_enable  output  1  RAM read enable; high only in FETCH
- ram_data  input  8  RAM read data; combinational, valid in the same cycle as ram_enable
- instr_data  output  8  instruction presented downstream
- instr_valid  output  1  instr_data is valid
- instr_ready  input  1  downstream accepts instr_data
- instr_count  output  8  number of instructions accepted since the last start
- busy  output  1  high in FETCH and ISSUE
- done  output  1  one-cycle pulse when the program terminates
- error  output  1  sticky flag: MEM_DEPTH reached without a terminator; cleared on start

Behaviour:
- Reset, applied on any clk edge with rst=1 from any state:
  - state=IDLE.
  - All outputs are 0: ram_address, ram_enable, instr_data, instr_valid, instr_count, busy, done, error.
  - Reset overrides every other input in that cycle.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - On start=1: clear instr_count and error, set ram_address=START_ADDR, go to FETCH.
  - Otherwise hold.
- FETCH:
  - ram_enable=1; ram_data is registered at the end of the cycle.
  - If ram_address >= MEM_DEPTH: set error=1, go to DONE, no RAM read is used.
  - Else if ram_data == END_OF_PROGRAM: go to DONE.
  - Else: instr_data <= ram_data, go to ISSUE.
- ISSUE:
  - instr_valid=1; instr_data is held stable while instr_ready=0.
  - On instr_valid & instr_ready in the same cycle:
    - instr_count increments, saturating at 8'hFF.
    - ram_address increments.
    - Go to FETCH; instr_valid drops in the next cycle.
- DONE:
  - done=1 for exactly this one cycle, busy=0, then IDLE.
  - ram_address holds the terminating address for debug.
- Latency:
  - start in cycle N puts FETCH in cycle N+1.
  - First instr_valid appears in cycle N+2.
  - Steady-state throughput is one instruction per 2 cycles when instr_ready is tied high.
- ram_enable is 0 in every state except FETCH, so the RAM output floats when the block is idle.
- instr_valid never asserts in IDLE, FETCH or DONE.
- start asserted while busy, or in DONE, is ignored.
- Address wrap:
  - ram_address increments as 8 bits.
  - Reaching MEM_DEPTH (128) is detected in FETCH and terminates with error before any wrap to 0 can occur.
- Terminator at START_ADDR: done pulses with instr_count=0 and no instr_valid.
- instr_ready=1 outside ISSUE has no effect.
- Reset mid-ISSUE drops the pending instruction; the next start restarts from START_ADDR.

Test Plan:
- Program RAM[0..4] = 4, 3, 8, 5, FF; instr_ready=1; pulse start:
  - Issued sequence is 4, 3, 8, 5, one per 2 cycles.
  - First instr_valid is 2 cycles after start.
  - done pulses once, instr_count=4, error=0, busy falls on the same cycle done rises.
- Same program, instr_ready held low for 3 cycles on each instruction:
  - instr_data stays stable while stalled; no drops or duplicates.
  - Final instr_count=4.
- RAM[0] = FF; start:
  - done pulses in cycle start+2.
  - instr_valid never asserts, instr_count=0.
- RAM filled with 8'h01, no terminator:
  - 128 instructions are issued.
  - At address 128: error=1 and done pulses; ram_enable stays 0 in that FETCH.
  - Next start clears error.
- rst=1 asserted during ISSUE of instruction 2 (value 3):
  - Next cycle all outputs are 0 and state is IDLE.
  - A new start reissues 4, 3, 8, 5.
- start re-pulsed during ISSUE and during DONE:
  - Both are ignored.
  - Sequence and instr_count are identical to scenario 1.
